i2c_xfer_sequencer: RTL and testbench

Hardware sequencer that turns one register-level I2C request (device address, register pointer, 1..MAX_LEN data bytes, read or write) into the ordered command stream for a byte-level I2C engine. It sits between a requester (CPU-side register block or an autonomous sensor poller) and the byte controller driving the open-drain io_i2c_scl/io_i2c_sda pads. It generates START, repeated START, ACK/NACK and STOP, and reports NACK, arbitration loss and timeout.

---
 rtl/i2c_seq_pkg.sv | 15 +
 rtl/i2c_seq_watchdog.sv | 28 ++
 rtl/i2c_xfer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_i2c_xfer_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared states, error codes and command word for the I2C transfer sequencer
package i2c_seq_pkg;
  typedef enum logic [3:0] {IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP_ERR, GAP, RESP} state_t;
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;
  typedef struct packed {
    logic start;
    logic stop;
    logic read;
    logic write;
    logic ack_in;
  } cmd_t;
endpackage

// File: rtl/i2c_seq_watchdog.sv
// i2c_seq_watchdog: loadable down-counter that pulses expire when a byte command hangs
module i2c_seq_watchdog #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  assign expire = run_q && cnt_q == '0;
  always_comb begin
    run_d = load | (run_q & ~clr & ~expire);
    cnt_d = load ? W'(TIMEOUT_CYC) : (run_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: turns one register-level I2C request into byte-engine commands
module i2c_xfer_sequencer import i2c_seq_pkg::*; #(
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rnw,
  input  logic [6:0]               req_dev,
  input  logic [7:0]               req_reg,
  input  logic [$clog2(MAX_LEN)-1:0] req_len,
  input  logic [8*MAX_LEN-1:0]     req_wdata,
  output logic                     rsp_valid,
  output logic [1:0]               rsp_err,
  output logic [8*MAX_LEN-1:0]     rsp_rdata,
  output logic                     busy,
  output logic                     bc_start,
  output logic                     bc_stop,
  output logic                     bc_read,
  output logic                     bc_write,
  output logic                     bc_ack_in,
  output logic [7:0]               bc_din,
  input  logic [7:0]               bc_dout,
  input  logic                     bc_cmd_ack,
  input  logic                     bc_ack_out,
  input  logic                     bc_al
);
  localparam int LW = $clog2(MAX_LEN);
  state_t state_q, state_d, nxt_q, nxt_d, tgt;
  cmd_t cmd_q, cmd_d;
  logic [7:0] din_q, din_d, reg_q, reg_d;
  logic [6:0] dev_q, dev_d;
  logic rnw_q, rnw_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [8*MAX_LEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] err_q, err_d;
  logic rsp_valid_q, rsp_valid_d, busy_q, busy_d, ready_q, ready_d;
  logic issue, fin, last, nack, wd_expire;
  assign last = cnt_q == len_q;
  assign nack = cmd_q.write & bc_ack_out;
  i2c_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .load   (issue),
    .clr    (bc_cmd_ack | fin),
    .expire (wd_expire)
  );
  always_comb begin
    state_d = state_q;
    nxt_d = nxt_q;
    cmd_d = cmd_q;
    din_d = din_q;
    rnw_d = rnw_q;
    dev_d = dev_q;
    reg_d = reg_q;
    len_d = len_q;
    cnt_d = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    busy_d = busy_q;
    ready_d = ready_q;
    rsp_valid_d = 1'b0;
    issue = 1'b0;
    fin = 1'b0;
    tgt = nxt_q;
    if (state_q == IDLE || state_q == RESP) begin
      state_d = IDLE;
      if (req_valid) begin
        rnw_d = req_rnw;
        dev_d = req_dev;
        reg_d = req_reg;
        len_d = req_len;
        wdata_d = req_wdata;
        rdata_d = '0;
        cnt_d = '0;
        err_d = ERR_OK;
        busy_d = 1'b1;
        ready_d = 1'b0;
        issue = 1'b1;
        tgt = ADDR_W;
      end
    end else if (bc_al || wd_expire) begin
      err_d = bc_al ? ERR_AL : ERR_TMO;
      fin = 1'b1;
    end else if (state_q == GAP) begin
      issue = 1'b1;
    end else if (bc_cmd_ack) begin
      cmd_d = '0;
      din_d = '0;
      state_d = GAP;
      if (state_q == RDATA) rdata_d[cnt_q*8 +: 8] = bc_dout;
      if ((state_q == WDATA || state_q == RDATA) && !last) cnt_d = cnt_q + 1'b1;
      nxt_d = state_q == ADDR_W ? REG : state_q == REG ? (rnw_q ? ADDR_R : WDATA) :
              state_q == ADDR_R ? RDATA : state_q;
      if (nack) begin
        err_d = ERR_NACK;
        nxt_d = STOP_ERR;
      end
      fin = cmd_q.stop;
    end
    if (fin) begin
      state_d = RESP;
      cmd_d = '0;
      din_d = '0;
      rsp_valid_d = 1'b1;
      busy_d = 1'b0;
      ready_d = 1'b1;
    end
    if (issue) begin
      state_d = tgt;
      cmd_d.start = tgt == ADDR_W || tgt == ADDR_R;
      cmd_d.stop = tgt == STOP_ERR || ((tgt == WDATA || tgt == RDATA) && cnt_d == len_d);
      cmd_d.read = tgt == RDATA;
      cmd_d.write = tgt == ADDR_W || tgt == REG || tgt == WDATA || tgt == ADDR_R;
      cmd_d.ack_in = tgt == RDATA && cnt_d == len_d;
      din_d = tgt == ADDR_W ? {dev_d, 1'b0} : tgt == ADDR_R ? {dev_d, 1'b1} :
              tgt == REG ? reg_d : tgt == WDATA ? wdata_d[cnt_d*8 +: 8] : 8'h00;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nxt_q <= IDLE;
      cmd_q <= '0;
      din_q <= '0;
      rnw_q <= 1'b0;
      dev_q <= '0;
      reg_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= ERR_OK;
      busy_q <= 1'b0;
      ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q <= nxt_d;
      cmd_q <= cmd_d;
      din_q <= din_d;
      rnw_q <= rnw_d;
      dev_q <= dev_d;
      reg_q <= reg_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign req_ready = ready_q;
  assign busy = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = err_q;
  assign rsp_rdata = rdata_q;
  assign bc_start = cmd_q.start;
  assign bc_stop = cmd_q.stop;
  assign bc_read = cmd_q.read;
  assign bc_write = cmd_q.write;
  assign bc_ack_in = cmd_q.ack_in;
  assign bc_din = din_q;
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb_i2c_xfer_sequencer: scoreboard bench with a behavioural byte-engine model
module tb_i2c_xfer_sequencer;
  localparam int MAX_LEN = 8;
  localparam int TMO = 64;
  localparam logic [4:0] C_SW = 5'b10010;
  localparam logic [4:0] C_W  = 5'b00010;
  localparam logic [4:0] C_WS = 5'b01010;
  localparam logic [4:0] C_R  = 5'b00100;
  localparam logic [4:0] C_RL = 5'b01101;
  localparam logic [4:0] C_S  = 5'b01000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid, req_ready, req_rnw, rsp_valid, busy;
  logic [6:0] req_dev;
  logic [7:0] req_reg, bc_din, bc_dout;
  logic [2:0] req_len;
  logic [63:0] req_wdata, rsp_rdata;
  logic [1:0] rsp_err;
  logic bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_cmd_ack, bc_ack_out, bc_al;
  typedef struct {
    logic [4:0] cmd;
    logic [7:0] din;
    logic       ack_out;
    logic [7:0] dout;
    logic       al;
    logic       hang;
  } step_t;
  typedef struct {
    logic [1:0]  err;
    logic [63:0] rdata;
  } rsp_t;
  step_t exp_q[$];
  rsp_t rsp_q[$];
  step_t cur;
  rsp_t mon_e;
  int cyc = 0, last_evt = 0, rsp_seen = 0, n_chk = 0, n_pass = 0, ticks = 0;
  logic pend = 1'b0, held_bad = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  i2c_xfer_sequencer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read), .bc_write(bc_write),
    .bc_ack_in(bc_ack_in), .bc_din(bc_din), .bc_dout(bc_dout), .bc_cmd_ack(bc_cmd_ack),
    .bc_ack_out(bc_ack_out), .bc_al(bc_al)
  );
  function automatic logic [4:0] cmd_now();
    return {bc_start, bc_stop, bc_read, bc_write, bc_ack_in};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  function automatic void push(input logic [4:0] c, input logic [7:0] d, input logic ao,
                               input logic [7:0] dout, input logic al, input logic hang);
    step_t s;
    s.cmd = c;
    s.din = d;
    s.ack_out = ao;
    s.dout = dout;
    s.al = al;
    s.hang = hang;
    exp_q.push_back(s);
  endfunction
  // byte-engine model: checks each command against the queue, acks 5 cycles later
  initial begin
    bc_cmd_ack = 1'b0;
    bc_ack_out = 1'b0;
    bc_dout = 8'h00;
    bc_al = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bc_cmd_ack = 1'b0;
      bc_ack_out = 1'b0;
      bc_al = 1'b0;
      if (pend && cmd_now() == 5'b0) pend = 1'b0;
      else if (pend) begin
        if (cmd_now() != cur.cmd || bc_din != cur.din) held_bad = 1'b1;
        ticks++;
        if (ticks == 5 && !cur.hang) begin
          bc_cmd_ack = 1'b1;
          bc_ack_out = cur.ack_out;
          bc_dout = cur.dout;
          bc_al = cur.al;
          last_evt = cyc;
          pend = 1'b0;
          check("cmd_hold", held_bad, 1'b0);
        end
      end else if (cmd_now() != 5'b0) begin
        if (exp_q.size() == 0) begin
          check("cmd_unexpected", {cmd_now(), bc_din}, 13'h0);
          cur.cmd = cmd_now();
          cur.din = bc_din;
          cur.ack_out = 1'b0;
          cur.dout = 8'h00;
          cur.al = 1'b0;
          cur.hang = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("cmd_word", {cmd_now(), bc_din}, {cur.cmd, cur.din});
        end
        pend = 1'b1;
        ticks = 0;
        held_bad = 1'b0;
        if (cur.hang) last_evt = cyc + TMO;
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", {rsp_err, rsp_rdata}, 66'h0);
        else begin
          mon_e = rsp_q.pop_front();
          check("rsp_err", rsp_err, mon_e.err);
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_time", cyc, last_evt + 1);
          check("rsp_status", {cmd_now(), busy, req_ready}, 7'b0000001);
        end
        rsp_seen++;
      end
    end
  end
  task automatic issue(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [2:0] len, input logic [63:0] wd);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1;
    req_rnw = rnw;
    req_dev = dev;
    req_reg = rg;
    req_len = len;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rnw = ~rnw;
    req_dev = 7'h7F;
    req_reg = 8'hFF;
    req_len = 3'h7;
    req_wdata = '1;
    check("accept_timing", {bc_start, bc_write, busy, req_ready}, 4'b1110);
  endtask
  task automatic run_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [2:0] len, input logic [63:0] wd,
                         input logic [1:0] err, input logic [63:0] rd);
    rsp_t r;
    int target, n;
    r.err = err;
    r.rdata = rd;
    rsp_q.push_back(r);
    target = rsp_seen + 1;
    issue(rnw, dev, rg, len, wd);
    n = 0;
    while (rsp_seen < target && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("rsp_arrived", 64'(rsp_seen >= target), 64'd1);
    @(posedge clk);
    #1;
    check("rsp_one_cycle", {rsp_valid, busy, req_ready}, 3'b001);
    repeat (2) @(posedge clk);
    #1;
    check("rdata_held", rsp_rdata, rd);
  endtask
  initial begin
    int n, seen;
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, seen;
    req_valid = 1'b0;
    req_rnw = 1'b0;
    req_dev = '0;
    req_reg = '0;
    req_len = '0;
    req_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {cmd_now(), bc_din, req_ready, busy, rsp_valid, rsp_err}, {13'b0, 1'b1, 4'b0});
    check("reset_rdata", rsp_rdata, 64'h0);
    rst = 1'b0;
    push(C_SW, 8'h3A, 0, 0, 0, 0);
    push(C_W, 8'h2D, 0, 0, 0, 0);
    push(C_WS, 8'h08, 0, 0, 0, 0);
    run_req(1'b0, 7'h1D, 8'h2D, 3'd0, 64'h08, 2'b00, 64'h0);
    push(C_SW, 8'h3A, 0, 0, 0, 0);
    push(C_W, 8'h32, 0, 0, 0, 0);
    push(C_SW, 8'h3B, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(C_R, 8'h00, 0, 8'(8'h11 * (i + 1)), 0, 0);
    push(C_RL, 8'h00, 0, 8'h66, 0, 0);
    run_req(1'b1, 7'h1D, 8'h32, 3'd5, 64'h0, 2'b00, 64'h665544332211);
    push(C_SW, 8'hA0, 1, 0, 0, 0);
    push(C_S, 8'h00, 0, 0, 0, 0);
    run_req(1'b0, 7'h50, 8'h10, 3'd1, 64'hBBAA, 2'b01, 64'h0);
    push(C_SW, 8'h3A, 0, 0, 0, 0);
    push(C_W, 8'h2D, 0, 0, 0, 0);
    push(C_WS, 8'h5A, 1, 0, 0, 0);
    run_req(1'b0, 7'h1D, 8'h2D, 3'd0, 64'h5A, 2'b01, 64'h0);
    push(C_SW, 8'h3A, 0, 0, 0, 0);
    push(C_W, 8'h0F, 0, 0, 1, 0);
    run_req(1'b1, 7'h1D, 8'h0F, 3'd0, 64'h0, 2'b10, 64'h0);
    push(C_SW, 8'h54, 0, 0, 0, 0);
    push(C_W, 8'h01, 0, 0, 0, 1);
    run_req(1'b0, 7'h2A, 8'h01, 3'd0, 64'hFF, 2'b11, 64'h0);
    push(C_SW, 8'hD0, 0, 0, 0, 0);
    push(C_W, 8'h3B, 0, 0, 0, 0);
    push(C_SW, 8'hD1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) push(C_R, 8'h00, 0, 8'(8'hA0 + i), 0, 0);
    push(C_RL, 8'h00, 0, 8'hA7, 0, 0);
    run_req(1'b1, 7'h68, 8'h3B, 3'd7, 64'h0, 2'b00, 64'hA7A6A5A4A3A2A1A0);
    push(C_SW, 8'h3A, 0, 0, 0, 0);
    push(C_W, 8'h32, 0, 0, 0, 0);
    push(C_SW, 8'h3B, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(C_R, 8'h00, 0, 8'(8'h11 * (i + 1)), 0, 0);
    push(C_RL, 8'h00, 0, 8'h66, 0, 0);
    seen = rsp_seen;
    issue(1'b1, 7'h1D, 8'h32, 3'd5, 64'h0);
    n = 0;
    while (!bc_read && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reached_rdata", bc_read, 1'b1);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_state", {cmd_now(), bc_din, req_ready, busy, rsp_valid, rsp_err}, {13'b0, 1'b1, 4'b0});
    check("midreset_rdata", rsp_rdata, 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("no_rsp_after_reset", rsp_seen, seen);
    push(C_SW, 8'h78, 0, 0, 0, 0);
    push(C_W, 8'h20, 0, 0, 0, 0);
    push(C_W, 8'h01, 0, 0, 0, 0);
    push(C_W, 8'h02, 0, 0, 0, 0);
    push(C_WS, 8'h03, 0, 0, 0, 0);
    run_req(1'b0, 7'h3C, 8'h20, 3'd2, 64'h030201, 2'b00, 64'h0);
    repeat (10) @(posedge clk);
    #2;
    check("queues_drained", {32'(exp_q.size()), 32'(rsp_q.size())}, 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
